// File: rtl/sockit_spi_ser.sv
// SPI mode-0 serializer: drains command words onto standard/dual/quad SPI pins at clk/2
// and returns captured read data. Quad I/O is present only when SOCKIT_SPI_SER_QUAD_EN is defined.
module sockit_spi_ser #(
  parameter int DW = 32,
  parameter int LW = $clog2(DW)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] cmd_dat,
  input  logic [LW-1:0] cmd_len,
  input  logic [1:0]    cmd_iom,
  input  logic          cmd_wen,
  input  logic          cmd_ren,
  input  logic          cmd_ssh,
  input  logic          cmd_vld,
  output logic          cmd_rdy,
  output logic [DW-1:0] rsp_dat,
  output logic          rsp_vld,
  input  logic          rsp_rdy,
  output logic          spi_sclk,
  output logic          spi_ss_n,
  output logic [3:0]    spi_sio_o,
  output logic [3:0]    spi_sio_e,
  input  logic [3:0]    spi_sio_i
);

  typedef enum logic [1:0] {IDL, SHF, RSP} state_t;

  localparam logic [1:0] M_STD  = 2'd0;
  localparam logic [1:0] M_DUAL = 2'd1;
  localparam logic [1:0] M_QUAD = 2'd2;
`ifdef SOCKIT_SPI_SER_QUAD_EN
  localparam logic [3:0] PIN_MASK = 4'b1111;
`else
  localparam logic [3:0] PIN_MASK = 4'b0011;
`endif

  state_t          state, state_nxt;
  logic [DW-1:0]   shreg;
  logic [DW-1:0]   rdreg;
  logic [LW-1:0]   cnt;
  logic [1:0]      mode;
  logic            wen_q, ren_q, ssh_q;
  logic            sclk_q, ss_n_q, rsp_vld_q;
  logic [3:0]      sio_o_q, sio_e_q;
  logic            last_unit;

  // Reserved mode 3 falls back to standard; without quad support mode 2 degrades to dual.
  function automatic logic [1:0] mode_dec(input logic [1:0] iom);
    case (iom)
      2'd1:    mode_dec = M_DUAL;
`ifdef SOCKIT_SPI_SER_QUAD_EN
      2'd2:    mode_dec = M_QUAD;
`else
      2'd2:    mode_dec = M_DUAL;
`endif
      default: mode_dec = M_STD;
    endcase
  endfunction

  function automatic logic [3:0] unit_out(input logic [1:0] m, input logic [DW-1:0] sr);
    case (m)
      M_QUAD:  unit_out = sr[DW-1 -: 4];
      M_DUAL:  unit_out = {2'b00, sr[DW-1 -: 2]};
      default: unit_out = {3'b000, sr[DW-1]};
    endcase
  endfunction

  function automatic logic [DW-1:0] shift_unit(input logic [1:0] m, input logic [DW-1:0] sr);
    case (m)
      M_QUAD:  shift_unit = {sr[DW-5:0], 4'b0000};
      M_DUAL:  shift_unit = {sr[DW-3:0], 2'b00};
      default: shift_unit = {sr[DW-2:0], 1'b0};
    endcase
  endfunction

  // Standard mode reads MISO on sio[1]; wider modes take the low u pins.
  function automatic logic [DW-1:0] sample_in(input logic [1:0] m, input logic [DW-1:0] rd,
                                              input logic [3:0] sio);
    case (m)
      M_QUAD:  sample_in = {rd[DW-5:0], sio};
      M_DUAL:  sample_in = {rd[DW-3:0], sio[1:0]};
      default: sample_in = {rd[DW-2:0], sio[1]};
    endcase
  endfunction

  function automatic logic [3:0] oe_mask(input logic [1:0] m);
    case (m)
      M_QUAD:  oe_mask = 4'b1111;
      M_DUAL:  oe_mask = 4'b0011;
      default: oe_mask = 4'b0001;
    endcase
  endfunction

  assign last_unit = sclk_q && (cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDL;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDL:     if (cmd_vld) state_nxt = SHF;
      SHF:     if (last_unit) state_nxt = ren_q ? RSP : IDL;
      RSP:     if (rsp_rdy) state_nxt = IDL;
      default: state_nxt = IDL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode      <= M_STD;
      wen_q     <= 1'b0;
      ren_q     <= 1'b0;
      ssh_q     <= 1'b0;
      cnt       <= '0;
      sclk_q    <= 1'b0;
      ss_n_q    <= 1'b1;
      sio_o_q   <= 4'b0000;
      sio_e_q   <= 4'b0000;
      rsp_vld_q <= 1'b0;
      rdreg     <= '0;
    end else begin
      case (state)
        IDL: begin
          if (cmd_vld) begin
            mode    <= mode_dec(cmd_iom);
            wen_q   <= cmd_wen;
            ren_q   <= cmd_ren;
            ssh_q   <= cmd_ssh;
            cnt     <= cmd_len;
            ss_n_q  <= 1'b0;
            rdreg   <= '0;
            sio_o_q <= cmd_wen ? unit_out(mode_dec(cmd_iom), cmd_dat) : 4'b0000;
            sio_e_q <= cmd_wen ? oe_mask(mode_dec(cmd_iom)) : 4'b0000;
          end
        end
        SHF: begin
          if (!sclk_q) begin
            // Rising SCLK edge: capture the slave's bits.
            sclk_q <= 1'b1;
            if (ren_q) rdreg <= sample_in(mode, rdreg, spi_sio_i);
          end else begin
            sclk_q <= 1'b0;
            if (cnt == '0) begin
              sio_o_q   <= 4'b0000;
              sio_e_q   <= 4'b0000;
              ss_n_q    <= ~ssh_q;
              rsp_vld_q <= ren_q;
            end else begin
              cnt <= cnt - LW'(1);
              if (wen_q) sio_o_q <= unit_out(mode, shift_unit(mode, shreg));
            end
          end
        end
        RSP: if (rsp_rdy) rsp_vld_q <= 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDL && cmd_vld)  shreg <= cmd_dat;
    else if (state == SHF && sclk_q) shreg <= shift_unit(mode, shreg);
  end

  assign cmd_rdy   = (state == IDL);
  assign rsp_dat   = rdreg;
  assign rsp_vld   = rsp_vld_q;
  assign spi_sclk  = sclk_q;
  assign spi_ss_n  = ss_n_q;
  assign spi_sio_o = sio_o_q & PIN_MASK;
  assign spi_sio_e = sio_e_q & PIN_MASK;

endmodule

// File: tb/tb_sockit_spi_ser.sv
// Directed bench for sockit_spi_ser: standard/dual/quad transfers, slave-select hold,
// dummy cycles and asynchronous reset, with hand-computed expectations.
module tb_sockit_spi_ser;

  localparam int DW = 32;
  localparam int LW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] cmd_dat;
  logic [LW-1:0] cmd_len;
  logic [1:0]    cmd_iom;
  logic          cmd_wen, cmd_ren, cmd_ssh, cmd_vld;
  logic          cmd_rdy;
  logic [DW-1:0] rsp_dat;
  logic          rsp_vld;
  logic          rsp_rdy;
  logic          spi_sclk, spi_ss_n;
  logic [3:0]    spi_sio_o, spi_sio_e, spi_sio_i;

  int n_vec = 0;
  int n_err = 0;

  sockit_spi_ser #(.DW(DW), .LW(LW)) dut (
    .clk(clk), .rst(rst),
    .cmd_dat(cmd_dat), .cmd_len(cmd_len), .cmd_iom(cmd_iom),
    .cmd_wen(cmd_wen), .cmd_ren(cmd_ren), .cmd_ssh(cmd_ssh),
    .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
    .rsp_dat(rsp_dat), .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy),
    .spi_sclk(spi_sclk), .spi_ss_n(spi_ss_n),
    .spi_sio_o(spi_sio_o), .spi_sio_e(spi_sio_e), .spi_sio_i(spi_sio_i)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected summary before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a command at a negedge; returns at the negedge of cycle 1.
  task automatic issue(input logic [31:0] dat, input logic [4:0] len, input logic [1:0] iom,
                       input logic wen, input logic ren, input logic ssh);
    @(negedge clk);
    chk("issue_cmd_rdy", {31'd0, cmd_rdy}, 32'd1);
    cmd_dat = dat; cmd_len = len; cmd_iom = iom;
    cmd_wen = wen; cmd_ren = ren; cmd_ssh = ssh;
    cmd_vld = 1'b1;
    @(negedge clk);
    cmd_vld = 1'b0;
    cmd_dat = '0;
  endtask

  initial begin
    logic [7:0]  pat;
    logic [31:0] exp_q;
    int          pulses;

    rst = 1'b1; cmd_dat = '0; cmd_len = '0; cmd_iom = 2'd0;
    cmd_wen = 0; cmd_ren = 0; cmd_ssh = 0; cmd_vld = 0;
    rsp_rdy = 0; spi_sio_i = 4'h0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_cmd_rdy", {31'd0, cmd_rdy}, 32'd1);
    chk("rst_rsp_vld", {31'd0, rsp_vld}, 32'd0);
    chk("rst_rsp_dat", rsp_dat, 32'd0);
    chk("rst_sclk", {31'd0, spi_sclk}, 32'd0);
    chk("rst_ss_n", {31'd0, spi_ss_n}, 32'd1);
    chk("rst_sio_o", {28'd0, spi_sio_o}, 32'd0);
    chk("rst_sio_e", {28'd0, spi_sio_e}, 32'd0);
    rst = 1'b0;

    // Standard write A5: bits 1,0,1,0,0,1,0,1 on sio_o[0]
    pat = 8'hA5;
    pulses = 0;
    issue(32'hA500_0000, 5'd7, 2'd0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      chk("wr_sio_o", {28'd0, spi_sio_o}, {31'd0, pat[7-k]});
      chk("wr_sio_e", {28'd0, spi_sio_e}, 32'h1);
      chk("wr_sclk_lo", {31'd0, spi_sclk}, 32'd0);
      chk("wr_ss_n_lo", {31'd0, spi_ss_n}, 32'd0);
      @(negedge clk);
      if (spi_sclk) pulses++;
      chk("wr_ss_n_hi", {31'd0, spi_ss_n}, 32'd0);
      chk("wr_cmd_rdy_busy", {31'd0, cmd_rdy}, 32'd0);
      @(negedge clk);
    end
    chk("wr_pulses", pulses, 32'd8);
    chk("wr_end_ss_n", {31'd0, spi_ss_n}, 32'd1);
    chk("wr_end_sclk", {31'd0, spi_sclk}, 32'd0);
    chk("wr_end_sio_e", {28'd0, spi_sio_e}, 32'd0);
    chk("wr_end_rsp_vld", {31'd0, rsp_vld}, 32'd0);
    chk("wr_end_cmd_rdy", {31'd0, cmd_rdy}, 32'd1);

    // Standard read 3C on sio_i[1], response held with rsp_rdy=0
    pat = 8'h3C;
    issue(32'h0000_0000, 5'd7, 2'd0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) begin
      spi_sio_i = {2'b00, pat[7-k], 1'b0};
      chk("rd_sio_e", {28'd0, spi_sio_e}, 32'd0);
      @(negedge clk);
      chk("rd_rsp_vld_busy", {31'd0, rsp_vld}, 32'd0);
      @(negedge clk);
    end
    spi_sio_i = 4'h0;
    for (int i = 0; i < 5; i++) begin
      chk("rd_rsp_vld", {31'd0, rsp_vld}, 32'd1);
      chk("rd_rsp_dat", rsp_dat, 32'h0000_003C);
      chk("rd_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
      chk("rd_ss_n", {31'd0, spi_ss_n}, 32'd1);
      @(negedge clk);
    end
    rsp_rdy = 1'b1;
    chk("rd_rsp_vld_hold", {31'd0, rsp_vld}, 32'd1);
    @(negedge clk);
    rsp_rdy = 1'b0;
    chk("rd_rsp_vld_done", {31'd0, rsp_vld}, 32'd0);
    chk("rd_cmd_rdy_done", {31'd0, cmd_rdy}, 32'd1);

    // Quad read: nibbles D then 7
`ifdef SOCKIT_SPI_SER_QUAD_EN
    exp_q = 32'h0000_00D7;
`else
    exp_q = 32'h0000_0007;
`endif
    issue(32'h0000_0000, 5'd1, 2'd2, 1'b0, 1'b1, 1'b0);
    spi_sio_i = 4'hD;
    chk("qrd_sio_e1", {28'd0, spi_sio_e}, 32'd0);
    @(negedge clk);
    chk("qrd_sio_e2", {28'd0, spi_sio_e}, 32'd0);
    @(negedge clk);
    spi_sio_i = 4'h7;
    chk("qrd_sio_e3", {28'd0, spi_sio_e}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    spi_sio_i = 4'h0;
    chk("qrd_rsp_vld", {31'd0, rsp_vld}, 32'd1);
    chk("qrd_rsp_dat", rsp_dat, exp_q);
    rsp_rdy = 1'b1;
    @(negedge clk);
    rsp_rdy = 1'b0;
    chk("qrd_rsp_vld_done", {31'd0, rsp_vld}, 32'd0);

    // Dual write B0..: units 2'b10 then 2'b11
    issue(32'hB000_0000, 5'd1, 2'd1, 1'b1, 1'b0, 1'b0);
    chk("dwr_sio_o0", {28'd0, spi_sio_o}, 32'h2);
    chk("dwr_sio_e0", {28'd0, spi_sio_e}, 32'h3);
    @(negedge clk);
    @(negedge clk);
    chk("dwr_sio_o1", {28'd0, spi_sio_o}, 32'h3);
    chk("dwr_sio_e1", {28'd0, spi_sio_e}, 32'h3);
    @(negedge clk);
    @(negedge clk);
    chk("dwr_end_sio_e", {28'd0, spi_sio_e}, 32'd0);
    chk("dwr_end_cmd_rdy", {31'd0, cmd_rdy}, 32'd1);

    // Slave select hold across two commands
    issue(32'h8000_0000, 5'd0, 2'd0, 1'b1, 1'b0, 1'b1);
    chk("ssh_a_ss_n", {31'd0, spi_ss_n}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("ssh_gap_ss_n", {31'd0, spi_ss_n}, 32'd0);
    chk("ssh_gap_cmd_rdy", {31'd0, cmd_rdy}, 32'd1);
    issue(32'h0000_0000, 5'd0, 2'd0, 1'b1, 1'b0, 1'b0);
    chk("ssh_b_ss_n", {31'd0, spi_ss_n}, 32'd0);
    @(negedge clk);
    chk("ssh_b_ss_n_hi", {31'd0, spi_ss_n}, 32'd0);
    @(negedge clk);
    chk("ssh_end_ss_n", {31'd0, spi_ss_n}, 32'd1);

    // Dummy transfer: 4 pulses, nothing driven or returned
    pulses = 0;
    issue(32'hFFFF_FFFF, 5'd3, 2'd0, 1'b0, 1'b0, 1'b0);
    for (int c = 1; c <= 8; c++) begin
      if (spi_sclk) pulses++;
      chk("dmy_sio_e", {28'd0, spi_sio_e}, 32'd0);
      if (c == 8) chk("dmy_cmd_rdy_c8", {31'd0, cmd_rdy}, 32'd0);
      @(negedge clk);
    end
    chk("dmy_pulses", pulses, 32'd4);
    chk("dmy_cmd_rdy_c9", {31'd0, cmd_rdy}, 32'd1);
    chk("dmy_rsp_vld", {31'd0, rsp_vld}, 32'd0);

    // Asynchronous reset in the middle of a transfer
    issue(32'hFFFF_FFFF, 5'd7, 2'd0, 1'b1, 1'b1, 1'b1);
    spi_sio_i = 4'hF;
    repeat (5) @(negedge clk);
    chk("mid_sclk_pre", {31'd0, spi_sclk}, 32'd1);
    chk("mid_sio_e_pre", {28'd0, spi_sio_e}, 32'h1);
    rst = 1'b1;
    #1;
    chk("mid_sclk", {31'd0, spi_sclk}, 32'd0);
    chk("mid_ss_n", {31'd0, spi_ss_n}, 32'd1);
    chk("mid_sio_o", {28'd0, spi_sio_o}, 32'd0);
    chk("mid_sio_e", {28'd0, spi_sio_e}, 32'd0);
    chk("mid_rsp_dat", rsp_dat, 32'd0);
    chk("mid_rsp_vld", {31'd0, rsp_vld}, 32'd0);
    chk("mid_cmd_rdy", {31'd0, cmd_rdy}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    spi_sio_i = 4'h0;
    @(negedge clk);
    chk("post_cmd_rdy", {31'd0, cmd_rdy}, 32'd1);
    chk("post_ss_n", {31'd0, spi_ss_n}, 32'd1);
    chk("post_rsp_vld", {31'd0, rsp_vld}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
